// File: rtl/register_file.sv
// Architectural register file with ROB rename tags.
// Holds committed values, a busy flag and the producing ROB tag per register.
// Read ports are combinational and forward a same-cycle commit to a waiting source.
module register_file #(
  parameter int unsigned ROB_INDEX_BIT = 4,
  parameter int unsigned REG_NUM       = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     issue_req,
  input  logic [4:0]               issue_rd,
  input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_val,
  input  logic [ROB_INDEX_BIT-1:0] commit_rob_id,
  input  logic [4:0]               rs1_idx,
  input  logic [4:0]               rs2_idx,
  output logic [31:0]              rs1_val,
  output logic                     rs1_busy,
  output logic [ROB_INDEX_BIT-1:0] rs1_rob_id,
  output logic [31:0]              rs2_val,
  output logic                     rs2_busy,
  output logic [ROB_INDEX_BIT-1:0] rs2_rob_id
);

  logic [31:0]              r_val  [REG_NUM];
  logic                     r_busy [REG_NUM];
  logic [ROB_INDEX_BIT-1:0] r_tag  [REG_NUM];

  logic w_hit1;
  logic w_hit2;

  // State update: commit write first, then flush or rename overrides the busy/tag result.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        r_val[i]  <= '0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_rd != 5'd0) begin
        r_val[commit_rd] <= commit_val;
        // Only the youngest producer may release the register.
        if (r_busy[commit_rd] && (r_tag[commit_rd] == commit_rob_id)) begin
          r_busy[commit_rd] <= 1'b0;
        end
      end
      if (clear_in) begin
        for (int i = 0; i < int'(REG_NUM); i++) begin
          r_busy[i] <= 1'b0;
        end
      end else if (issue_req && (issue_rd != 5'd0)) begin
        r_busy[issue_rd] <= 1'b1;
        r_tag[issue_rd]  <= issue_rob_id;
      end
    end
  end

  // Same-cycle commit bypass detection; deliberately independent of rdy_in/clear_in.
  assign w_hit1 = r_busy[rs1_idx] && (commit_rd == rs1_idx) && (r_tag[rs1_idx] == commit_rob_id);
  assign w_hit2 = r_busy[rs2_idx] && (commit_rd == rs2_idx) && (r_tag[rs2_idx] == commit_rob_id);

  // Read port 1: x0 forced to zero, otherwise stored state with commit forwarding.
  always_comb begin
    rs1_val    = r_val[rs1_idx];
    rs1_busy   = r_busy[rs1_idx];
    rs1_rob_id = r_tag[rs1_idx];
    if (rs1_idx == 5'd0) begin
      rs1_val    = '0;
      rs1_busy   = 1'b0;
      rs1_rob_id = '0;
    end else if (w_hit1) begin
      rs1_val  = commit_val;
      rs1_busy = 1'b0;
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    rs2_val    = r_val[rs2_idx];
    rs2_busy   = r_busy[rs2_idx];
    rs2_rob_id = r_tag[rs2_idx];
    if (rs2_idx == 5'd0) begin
      rs2_val    = '0;
      rs2_busy   = 1'b0;
      rs2_rob_id = '0;
    end else if (w_hit2) begin
      rs2_val  = commit_val;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read results from a
// reference model, a monitor pops and compares them at the falling edge.
module tb_register_file;
  localparam int RB = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear_in, issue_req;
  logic [4:0]    issue_rd, commit_rd, rs1_idx, rs2_idx;
  logic [RB-1:0] issue_rob_id, commit_rob_id, rs1_rob_id, rs2_rob_id;
  logic [31:0]   commit_val, rs1_val, rs2_val;
  logic          rs1_busy, rs2_busy;

  always #5 clk_in = ~clk_in;

  register_file #(.ROB_INDEX_BIT(RB), .REG_NUM(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_req(issue_req), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_rob_id(rs1_rob_id),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_rob_id(rs2_rob_id)
  );

  typedef struct {
    logic [4:0]    idx1, idx2;
    logic [31:0]   v1, v2;
    logic          b1, b2;
    logic [RB-1:0] t1, t2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference architectural state.
  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RB-1:0] m_tag  [32];

  task automatic chk(input string name, input logic [4:0] idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (x%0d): got %h, want %h", name, idx, act, exp);
    end
  endtask

  // What a source read should return given current architectural state and this cycle's commit.
  task automatic model_read(input logic [4:0] r, input logic [4:0] crd,
                            input logic [31:0] cval, input logic [RB-1:0] ctag,
                            output logic [31:0] v, output logic b, output logic [RB-1:0] t);
    if (r == 0) begin
      v = 0; b = 0; t = 0;
    end else begin
      t = m_tag[r];
      if (m_busy[r] && crd == r && m_tag[r] == ctag) begin
        v = cval; b = 0;
      end else begin
        v = m_val[r]; b = m_busy[r];
      end
    end
  endtask

  // Drive one cycle, push the expected reads, then advance the model past the posedge.
  task automatic cyc(input logic rst, input logic rdy, input logic clr, input logic ireq,
                     input logic [4:0] ird, input logic [RB-1:0] itag,
                     input logic [4:0] crd, input logic [31:0] cval, input logic [RB-1:0] ctag,
                     input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    rst_in = rst; rdy_in = rdy; clear_in = clr; issue_req = ireq;
    issue_rd = ird; issue_rob_id = itag;
    commit_rd = crd; commit_val = cval; commit_rob_id = ctag;
    rs1_idx = r1; rs2_idx = r2;
    if (!rst) begin
      e.idx1 = r1; e.idx2 = r2;
      model_read(r1, crd, cval, ctag, e.v1, e.b1, e.t1);
      model_read(r2, crd, cval, ctag, e.v2, e.b2, e.t2);
      q.push_back(e);
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (rdy) begin
      if (crd != 0) begin
        m_val[crd] = cval;
        if (m_busy[crd] && m_tag[crd] == ctag) m_busy[crd] = 0;
      end
      if (clr) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (ireq && ird != 0) begin
        m_busy[ird] = 1;
        m_tag[ird]  = itag;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic rd2(input logic [4:0] r1, input logic [4:0] r2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic issue(input logic [4:0] ird, input logic [RB-1:0] itag,
                       input logic [4:0] r1, input logic [4:0] r2);
    cyc(0, 1, 0, 1, ird, itag, 0, 0, 0, r1, r2);
  endtask

  task automatic commit(input logic [4:0] crd, input logic [31:0] cval,
                        input logic [RB-1:0] ctag, input logic [4:0] r1, input logic [4:0] r2);
    cyc(0, 1, 0, 0, 0, 0, crd, cval, ctag, r1, r2);
  endtask

  // Monitor: read outputs are valid every non-reset cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs1_busy", e.idx1, 32'(rs1_busy), 32'(e.b1));
        chk("rs1_rob_id", e.idx1, 32'(rs1_rob_id), 32'(e.t1));
        if (!e.b1) chk("rs1_val", e.idx1, rs1_val, e.v1);
        chk("rs2_busy", e.idx2, 32'(rs2_busy), 32'(e.b2));
        chk("rs2_rob_id", e.idx2, 32'(rs2_rob_id), 32'(e.t2));
        if (!e.b2) chk("rs2_val", e.idx2, rs2_val, e.v2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]    crd, ird, r1, r2;
    logic [RB-1:0] ctag;
    // Reset and sweep every register.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) rd2(5'(2 * i), 5'(2 * i + 1));

    // Rename then same-cycle commit bypass.
    issue(5, 3, 0, 0);
    rd2(5, 0);
    commit(5, 32'h1234, 3, 5, 5);
    rd2(5, 5);

    // Older producer commits while a newer one is in flight.
    issue(7, 2, 7, 0);
    issue(7, 6, 7, 0);
    commit(7, 9, 2, 7, 0);
    rd2(7, 7);
    commit(7, 11, 6, 7, 0);
    rd2(7, 0);

    // Issue and commit to the same register in one cycle: issue keeps it busy.
    issue(8, 1, 0, 0);
    cyc(0, 1, 0, 1, 8, 4, 8, 32'h55, 1, 8, 0);
    rd2(8, 8);
    commit(8, 32'h66, 4, 8, 0);
    rd2(8, 0);

    // Flush with a concurrent commit and an ignored issue.
    issue(3, 1, 0, 0);
    issue(9, 2, 0, 0);
    issue(12, 3, 3, 9);
    cyc(0, 1, 1, 1, 10, 5, 9, 32'hAA, 2, 9, 10);
    rd2(3, 12);
    rd2(9, 10);

    // Stalled cycle changes nothing.
    cyc(0, 0, 0, 1, 4, 7, 6, 32'h77, 0, 4, 6);
    rd2(4, 6);

    // x0 ignores writes and renames.
    cyc(0, 1, 0, 1, 0, 9, 0, 32'hFFFF, 0, 0, 0);
    rd2(0, 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      crd  = 5'($urandom_range(0, 31));
      ctag = ($urandom_range(0, 1) == 1) ? m_tag[crd] : RB'($urandom);
      ird  = 5'($urandom_range(0, 31));
      r1   = ($urandom_range(0, 2) == 0) ? crd : 5'($urandom);
      r2   = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom);
      cyc(0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
          1'($urandom), ird, RB'($urandom), crd, $urandom, ctag, r1, r2);
    end

    rd2(0, 0);
    @(posedge clk_in);
    chk("scoreboard_drained", 0, 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags.
- Sits between the instruction unit (issue side) and the reorder buffer (commit side).
- Provides operand values or ROB dependency tags to the instruction unit at issue.
- Records the producing ROB entry for each destination register, and writes committed results from the ROB.
- Drops all pending tags on a misprediction clear.

Parameters:
ROB_INDEX_BIT, 4, width of ROB entry index / rename tag (matches codebase const)
REG_NUM, 32, number of architectural registers (x0 hardwired zero)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  ready; state frozen when low
clear_in  input  1  ROB misprediction flush
issue_req  input  1  instruction issued this cycle
issue_rd  input  5  destination register of issued instruction
issue_rob_id  input  ROB_INDEX_BIT  ROB entry allocated to issued instruction
commit_rd  input  5  committed destination; 0 = no write
commit_val  input  32  committed result
commit_rob_id  input  ROB_INDEX_BIT  ROB entry being committed
rs1_idx  input  5  source register 1 index
rs2_idx  input  5  source register 2 index
rs1_val  output  32  value of rs1 (valid when rs1_busy=0)
rs1_busy  output  1  rs1 awaits ROB result
rs1_rob_id  output  ROB_INDEX_BIT  ROB tag rs1 waits on
rs2_val  output  32  as rs1
rs2_busy  output  1  as rs1
rs2_rob_id  output  ROB_INDEX_BIT  as rs1

Behaviour:
- State: val[0..31] (32b), busy[0..31], tag[0..31].
- Reset (rst_in=1 at posedge): all val=0, busy=0, tag=0. Outputs are combinational from state, so after reset rsN_val=0, rsN_busy=0, rsN_rob_id=0.
- rdy_in=0 and rst_in=0: no state change. Read outputs remain live.
- Commit write (posedge, rdy_in=1, commit_rd!=0): val[commit_rd] <= commit_val regardless of busy/tag.
  - busy[commit_rd] <= 0 only if busy=1 and tag==commit_rob_id; a newer in-flight producer keeps the register busy.
- Issue rename (posedge, rdy_in=1, issue_req=1, issue_rd!=0, clear_in=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
- Same cycle, issue_rd==commit_rd: value written from commit; busy=1 and tag=issue_rob_id (issue wins).
- clear_in=1 (rdy_in=1): all busy <= 0; commit write still applied; issue_req ignored.
- x0: writes and renames to index 0 ignored; val[0]=0, busy[0]=0 always.
- Combinational read, per port N with index r:
  - r==0: val=0, busy=0, rob_id=0.
  - hit = busy[r] && commit_rd==r && tag[r]==commit_rob_id: val=commit_val, busy=0, rob_id=tag[r] (same-cycle commit bypass).
  - else busy[r]=1: busy=1, rob_id=tag[r], val=val[r] (stale, don't care).
  - else: val=val[r], busy=0, rob_id=tag[r].
  - Reads never see same-cycle issue: an instruction reads its sources before its own rename, so "addi x5,x5,1" depends on the older x5 producer.
  - Bypass is not gated by rdy_in or clear_in.
- Latency: rename and write visible one cycle after the posedge; commit data visible same cycle through the bypass.
- Both read ports are independent; rs1_idx==rs2_idx yields identical outputs.

Test Plan:
- Reset, then read x0..x31 -> every rsN_val=0, rsN_busy=0.
- Issue rd=5, rob_id=3; next cycle read x5 -> busy=1, rob_id=3. Commit rd=5, val=0x1234, rob_id=3, rs1_idx=5 in same cycle -> rs1_busy=0, rs1_val=0x1234 combinationally; next cycle busy=0, val=0x1234.
- Issue rd=7 tag 2, then rd=7 tag 6; commit rd=7, rob_id=2, val=9 -> val[7]=9 but busy=1, rob_id=6; commit rob_id=6, val=11 -> busy=0, val=11.
- Same cycle: issue rd=8 tag 4 and commit rd=8 tag 1 (matching old tag), val=0x55 -> next cycle busy=1, rob_id=4, stored val=0x55 (visible after tag-4 commit only if overwritten).
- Registers 3, 9, 12 busy; clear_in=1 with commit rd=9, val=0xAA and issue rd=10 -> next cycle no register busy, val[9]=0xAA, x10 not renamed.
- rdy_in=0 with issue rd=4 and commit rd=6 -> no state change. Issue/commit to rd=0 -> x0 stays 0 and not busy.
